capture_ram: RTL

Parametrised trigger-aware sample capture buffer for the acquisition path; the successor to the fixed 2048×10 sample SRAM. It sits between the ADC sample register and the readout/USB side. It writes incoming samples circularly while armed and freezes a window with a programmable post-trigger count. Readout uses a logical address relative to the oldest retained sample, so downstream logic never handles wrap-around.

---
 rtl/capture_ram_if.sv | 31 +++
 rtl/capture_ram.sv | 135 +++++++++++++
 2 files changed

// File: rtl/capture_ram_if.sv
// Capture buffer bus: acquisition-side controls, readout address/data and status.
// The master drives the capture controls and read address.
// The slave (capture_ram) returns read data and status.
interface capture_ram_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 11
);
    logic              arm;
    logic              trig;
    logic              we;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              wrap;
    logic              filled;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] start_addr;

    modport master (
        output arm, trig, we, data_in, post_cnt, rd_addr,
        input  rd_data, busy, done, wrap, filled, trig_addr, start_addr
    );

    modport slave (
        input  arm, trig, we, data_in, post_cnt, rd_addr,
        output rd_data, busy, done, wrap, filled, trig_addr, start_addr
    );
endinterface

// File: rtl/capture_ram.sv
// capture_ram: trigger-aware circular sample capture buffer.
// While armed, samples are written circularly. A trigger freezes a window
// after a programmable number of post-trigger samples. Readout addresses
// are relative to the oldest retained sample, so readers never see the wrap.
// Optional macro CAPTURE_RAM_REGOUT_EN: registered read data (1-cycle latency,
// block-RAM friendly). When undefined, read data is combinational.
module capture_ram #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    capture_ram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_reg,      state_next;
    logic [ADDR_W-1:0] wr_addr_reg,    wr_addr_next;
    logic              filled_reg,     filled_next;
    logic              wrap_reg,       wrap_next;
    logic [ADDR_W-1:0] remaining_reg,  remaining_next;
    logic [ADDR_W-1:0] trig_addr_reg,  trig_addr_next;
    logic [ADDR_W-1:0] start_addr_reg, start_addr_next;
    logic              mem_we;
    logic [ADDR_W-1:0] rd_phys;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Next-state and control-register logic; arm overrides everything else.
    always_comb begin
        state_next      = state_reg;
        wr_addr_next    = wr_addr_reg;
        filled_next     = filled_reg;
        wrap_next       = 1'b0;
        remaining_next  = remaining_reg;
        trig_addr_next  = trig_addr_reg;
        start_addr_next = start_addr_reg;
        mem_we          = 1'b0;

        if (bus.arm) begin
            state_next      = ST_ARMED;
            wr_addr_next    = '0;
            filled_next     = 1'b0;
            start_addr_next = '0;
        end else if (bus.we && (state_reg == ST_ARMED || state_reg == ST_POST)) begin
            // Sample write common to ARMED and POST.
            mem_we       = 1'b1;
            wr_addr_next = wr_addr_reg + 1'b1;
            if (wr_addr_reg == LAST_ADDR) begin
                filled_next = 1'b1;
                wrap_next   = 1'b1;
            end

            if (state_reg == ST_ARMED) begin
                if (bus.trig) begin
                    // post_cnt is ADDR_W wide, so it can never exceed DEPTH-1:
                    // the trigger sample is never overwritten.
                    trig_addr_next = wr_addr_reg;
                    remaining_next = bus.post_cnt;
                    if (bus.post_cnt == '0) begin
                        state_next      = ST_DONE;
                        start_addr_next = filled_next ? wr_addr_next : '0;
                    end else begin
                        state_next = ST_POST;
                    end
                end
            end else begin
                remaining_next = remaining_reg - 1'b1;
                if (remaining_reg == ADDR_W'(1)) begin
                    state_next      = ST_DONE;
                    start_addr_next = filled_next ? wr_addr_next : '0;
                end
            end
        end
    end

    // Control register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            wr_addr_reg    <= '0;
            filled_reg     <= 1'b0;
            wrap_reg       <= 1'b0;
            remaining_reg  <= '0;
            trig_addr_reg  <= '0;
            start_addr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            wr_addr_reg    <= wr_addr_next;
            filled_reg     <= filled_next;
            wrap_reg       <= wrap_next;
            remaining_reg  <= remaining_next;
            trig_addr_reg  <= trig_addr_next;
            start_addr_reg <= start_addr_next;
        end
    end

    // Sample memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[wr_addr_reg] <= bus.data_in;
        end
    end

    // Logical-to-physical read mapping; natural ADDR_W overflow gives the modulo.
    assign rd_phys = start_addr_reg + bus.rd_addr;

`ifdef CAPTURE_RAM_REGOUT_EN
    logic [DATA_W-1:0] rd_data_reg;

    // Registered read port so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        rd_data_reg <= mem[rd_phys];
    end

    assign bus.rd_data = rd_data_reg;
`else
    assign bus.rd_data = mem[rd_phys];
`endif

    assign bus.busy       = (state_reg == ST_ARMED) || (state_reg == ST_POST);
    assign bus.done       = (state_reg == ST_DONE);
    assign bus.wrap       = wrap_reg;
    assign bus.filled     = filled_reg;
    assign bus.trig_addr  = trig_addr_reg;
    assign bus.start_addr = start_addr_reg;
endmodule
